// File: rtl/pipe_de_elastic.sv
// Elastic decode-to-execute pipeline register: valid/ready handshake, 2-entry skid buffer, flush.
// Optional PIPE_DE_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module pipe_de_elastic #(
    parameter int DATA_W = 32,
    parameter int LANES  = 25,
    parameter int CTRL_W = 10,
    parameter int OP_W   = 5,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    in_wr_reg,
    input  logic                    in_wr_mem,
    input  logic [OP_W-1:0]         in_opcode,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [DATA_W-1:0]       in_val_a,
    input  logic [DATA_W-1:0]       in_val_b,
    input  logic [ADDR_W-1:0]       in_dir_write,
    input  logic [LANES*DATA_W-1:0] in_lanes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic                    out_wr_reg,
    output logic                    out_wr_mem,
    output logic [OP_W-1:0]         out_opcode,
    output logic [DATA_W-1:0]       out_imm,
    output logic [DATA_W-1:0]       out_val_a,
    output logic [DATA_W-1:0]       out_val_b,
    output logic [ADDR_W-1:0]       out_dir_write,
    output logic [LANES*DATA_W-1:0] out_lanes
`ifdef PIPE_DE_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int PW = CTRL_W + 2 + OP_W + 3 * DATA_W + ADDR_W + LANES * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   m_reg;
    logic [PW-1:0]   s_reg;
    logic            load_m_in;
    logic            load_m_s;
    logic            load_s;
    logic            held_wr_reg;
    logic            held_wr_mem;

    assign in_payload = {in_ctrl, in_wr_reg, in_wr_mem, in_opcode, in_imm,
                         in_val_a, in_val_b, in_dir_write, in_lanes};

    // Handshake flags decode straight from the state flops, so in_ready never sees out_ready.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            EMPTY: begin
                if (in_valid) begin
                    state_next = HALF;
                end
            end
            HALF: begin
                if (in_valid && !out_ready) begin
                    state_next = FULL;
                end else if (!in_valid && out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next = HALF;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
        end
    end

    // In EMPTY/HALF in_ready is 1, so an accept there is just in_valid.
    always_comb begin
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        unique case (state_reg)
            EMPTY:   load_m_in = in_valid;
            HALF: begin
                load_m_in = in_valid && out_ready;
                load_s    = in_valid && !out_ready;
            end
            FULL:    load_m_s = out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg <= '0;
            s_reg <= '0;
        end else begin
            if (load_m_in) begin
                m_reg <= in_payload;
            end else if (load_m_s) begin
                m_reg <= s_reg;
            end
            if (load_s) begin
                s_reg <= in_payload;
            end
        end
    end

    assign {out_ctrl, held_wr_reg, held_wr_mem, out_opcode, out_imm,
            out_val_a, out_val_b, out_dir_write, out_lanes} = m_reg;

    // Write enables must never fire on a bubble, including the cycle after a flush.
    assign out_wr_reg = held_wr_reg & out_valid;
    assign out_wr_mem = held_wr_mem & out_valid;

`ifdef PIPE_DE_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
